wb_regfile: RTL
===============

# wb_regfile

Write-back register file with an outstanding-write scoreboard for the AAI_CPU datapath. It holds the 32×32 MIPS general-purpose registers and provides two combinational read ports and one write-back port. Per-register pending-write counters are driven by the destination address selected at issue (rd, rt or $ra via the 4:1 destination select). Decode uses the busy flags to detect RAW hazards and raise stall.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  instruction issuing with a register destination this cycle
- iss_dest  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  issue accepted (dest counter not saturated)
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- rs_busy  out  1  port A register has an outstanding write
- rt_busy  out  1  port B register has an outstanding write
- stall  out  1  rs_busy | rt_busy | (iss_valid & ~iss_ready)
- wb_valid  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data
- sb_err  out  1  sticky: write-back to a register with zero pending count

## Operation
- Storage: 32 registers. Register 0 reads 0 always. Writes to register 0 are discarded and never counted.
- Write: at the clk edge with wb_valid=1 and wb_addr≠0, reg[wb_addr] ← wb_data.
- Read: rs_data/rt_data combinationally reflect the array for the current address.
- Scoreboard: one 2-bit saturating count per register r=1..31, holding 0..3 outstanding writes.
  - Increment when iss_valid & iss_ready & iss_dest=r.
  - Decrement when wb_valid & wb_addr=r & count>0.
  - Both in the same cycle on the same r: count unchanged.
- iss_ready = 0 when iss_dest≠0 and count[iss_dest]=3. The issue is then ignored and the count is unchanged.
- iss_ready = 1 when iss_dest=0.
- Write-back with count=0: data is written, count stays 0, and sb_err is set and held until rst.
- busy(x) = (x≠0) & (count[x]≠0), before any bypass adjustment.

## Timing
- Read latency: 0 cycles (combinational).
- Write and scoreboard update latency: 1 edge. The new value is visible on read ports in the following cycle.
- Reset: all registers ← 0, all counts ← 0, sb_err ← 0.
- Outputs after reset: rs_data=rt_data=0, rs_busy=rt_busy=0, iss_ready=1, stall=0, sb_err=0.
- rst dominates every simultaneous issue or write-back, including mid-sequence with counts outstanding.
- Issue and read of the same register in one cycle: busy reflects the count before the increment. The issue's own hazard is seen from the next cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_valid & wb_addr=x≠0 on a read port, that port's data = wb_data in the same cycle.
  - That port's busy is forced 0 if count[x]=1.
- REGFILE_BYPASS_EN undefined:
  - Read ports return array contents only.
  - busy follows the count alone, so a consumer stalls one extra cycle after write-back.

## Structure
- Shared package wb_regfile_pkg holds:
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31
  - SB_CNT_MAX = 2'd3
  - typedef sb_cnt_t (2-bit count)
- Sub-module sb_cnt2: a single saturating up/down counter with inputs inc, dec and rst, and outputs cnt and underflow. It is instantiated 31 times (r=1..31).

## Test plan
- Reset then read: rst=1 for one cycle, then read r5 and r31 → rs_data=rt_data=0, busy=0, stall=0.
- Issue then write-back:
  - Issue dest=8, then rs_addr=8 → rs_busy=1, stall=1.
  - wb_addr=8, wb_data=32'hDEADBEEF → next cycle rs_data=DEADBEEF, rs_busy=0.
  - With bypass, rs_data=DEADBEEF and rs_busy=0 during the write-back cycle itself.
- Saturation:
  - Issue dest=9 three times → fourth issue sees iss_ready=0 and stall=1, count stays 3.
  - Three write-backs to r9 → busy clears after the third.
- Simultaneous issue and write-back on r10 with count=1 → count stays 1, rs_busy(10)=1, data updated.
- Register zero:
  - wb_addr=0, wb_data=32'h1234 → reads of r0 return 0.
  - Issue dest=0 → iss_ready=1, busy(0)=0.
- Underflow and reset:
  - Write-back to r3 with count 0 → r3 written, sb_err=1 and held.
  - Then rst mid-operation with r4 count=2 → all counts 0, sb_err=0, r3=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared constants and types for the write-back register
// file and its outstanding-write scoreboard.
//   REG_ZERO   - hardwired-zero register index
//   REG_RA     - return-address register index ($ra)
//   SB_CNT_MAX - saturation value of a per-register pending-write count
//   sb_cnt_t   - 2-bit pending-write count
package wb_regfile_pkg;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;
    localparam logic [1:0] SB_CNT_MAX = 2'd3;

    typedef logic [1:0] sb_cnt_t;

endpackage

// File: rtl/wb_regfile_sb_cnt2.sv
// sb_cnt2: one saturating 2-bit up/down pending-write counter.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (count -> 0)
//   inc       in   an accepted issue targets this register
//   dec       in   a write-back targets this register
//   cnt       out  current outstanding-write count (0..3)
//   underflow out  write-back arrived while count was 0 (combinational)
module sb_cnt2
    import wb_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt,
    output logic       underflow
);

    // A write-back only retires a pending write if one exists; a stray
    // write-back at zero is reported instead of wrapping.
    logic dec_eff;
    assign dec_eff   = dec & (cnt != 2'd0);
    assign underflow = dec & (cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
        end else begin
            case ({inc, dec_eff})
                2'b10:   if (cnt != SB_CNT_MAX) cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;   // idle, or issue and retire cancel
            endcase
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 write-back register file with a per-register
// outstanding-write scoreboard used by decode for RAW hazard stalls.
// Optional feature macro: REGFILE_BYPASS_EN (write-back data forwarded to
// the read ports in the write-back cycle, busy cleared for the last
// outstanding write).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   iss_valid, iss_dest, iss_ready issue with register destination
//   rs_addr/rs_data/rs_busy       read port A
//   rt_addr/rt_data/rt_busy       read port B
//   stall                         hazard or issue back-pressure
//   wb_valid, wb_addr, wb_data    write-back port
//   sb_err                        sticky write-back-without-pending error
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_err
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs [NREGS];
    logic [NREGS-1:0][1:0]    cnt;
    logic [NREGS-1:0]         uflow;
    logic                     wr_en;
    logic                     rs_busy_raw, rt_busy_raw;

    assign wr_en = wb_valid & (wb_addr != REG_ZERO);

    // Register 0 has no scoreboard entry.
    assign cnt[0]   = 2'd0;
    assign uflow[0] = 1'b0;

    assign iss_ready = (iss_dest == REG_ZERO) || (cnt[iss_dest] != SB_CNT_MAX);

    for (genvar r = 1; r < NREGS; r++) begin : g_sb
        sb_cnt2 u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (iss_valid & iss_ready & (iss_dest == ADDR_W'(r))),
            .dec       (wb_valid & (wb_addr == ADDR_W'(r))),
            .cnt       (cnt[r]),
            .underflow (uflow[r])
        );
    end

    // Entry 0 is never written, so it reads back as zero without a mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           sb_err <= 1'b0;
        else if (|uflow)   sb_err <= 1'b1;
    end

    assign rs_busy_raw = (rs_addr != REG_ZERO) & (cnt[rs_addr] != 2'd0);
    assign rt_busy_raw = (rt_addr != REG_ZERO) & (cnt[rt_addr] != 2'd0);

`ifdef REGFILE_BYPASS_EN
    logic rs_hit, rt_hit;
    assign rs_hit  = wr_en & (wb_addr == rs_addr);
    assign rt_hit  = wr_en & (wb_addr == rt_addr);
    assign rs_data = rs_hit ? wb_data : regs[rs_addr];
    assign rt_data = rt_hit ? wb_data : regs[rt_addr];
    // The arriving write-back retires the last pending write, so the
    // consumer can proceed this cycle on the forwarded data.
    assign rs_busy = rs_busy_raw & ~(rs_hit & (cnt[rs_addr] == 2'd1));
    assign rt_busy = rt_busy_raw & ~(rt_hit & (cnt[rt_addr] == 2'd1));
`else
    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];
    assign rs_busy = rs_busy_raw;
    assign rt_busy = rt_busy_raw;
`endif

    assign stall = rs_busy | rt_busy | (iss_valid & ~iss_ready);

endmodule
